mem_dma_copier: RTL
===================

// Module: mem_dma_copier
// PURPOSE
// - Bus initiator for the word-addressed RAM: drives addr/write_enable/data_in, samples combinational data_out.
// - Copies LEN 32-bit words from byte address SRC to byte address DST on command from the CPU/accelerator side.
// - Stages accelerator input/output matrices without CPU load/store loops; shares the RAM port through an arbiter grant.
// PARAMETERS
// - ADDR_LEN  16  word-address bits of target RAM; legal byte range 0 .. (1<<(ADDR_LEN+2))-1
// - CNT_W     16  width of length field (max 2^CNT_W-1 words per command)
// PORTS
// - clk        in   1      rising-edge clock
// - rst        in   1      synchronous active-high reset
// - cmd_valid  in   1      command request; accepted when cmd_ready=1
// - cmd_ready  out  1      1 in IDLE only
// - cmd_src    in   32     source byte address (word aligned)
// - cmd_dst    in   32     destination byte address (word aligned)
// - cmd_len    in   CNT_W  word count
// - busy       out  1      1 from acceptance until done pulse inclusive
// - done       out  1      one-cycle completion pulse
// - err        out  1      one-cycle pulse with done when command rejected
// - mem_gnt    in   1      arbiter grant; 0 stalls the current access
// - mem_addr   out  32     byte address to RAM
// - mem_we     out  1      RAM write_enable
// - mem_wdata  out  32     RAM data_in
// - mem_rdata  in   32     RAM data_out (combinational, same cycle as mem_addr)
// - checksum   out  32     only with MEM_DMA_CHECKSUM_EN (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state=IDLE, cmd_ready=1, busy=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0, counters/ptrs/buffer=0.
//   rst mid-transfer aborts immediately; words already written stay written; no done/err.
// - FSM: IDLE -> (cmd_valid) CHECK -> READ <-> WRITE -> DONE -> IDLE.
//   IDLE: latch src/dst/len on cmd_valid&cmd_ready; cmd_valid ignored in all other states.
//   CHECK (1 cycle): src[1:0]!=0, dst[1:0]!=0, or last word of either range beyond byte limit -> DONE with err.
//     len==0 -> DONE, no memory access, err=0.
//   READ: mem_addr=src_ptr, mem_we=0; if mem_gnt: buffer<=mem_rdata, src_ptr+=4, go WRITE; else hold.
//   WRITE: mem_addr=dst_ptr, mem_we=mem_gnt, mem_wdata=buffer; if mem_gnt: dst_ptr+=4, remaining-=1,
//     go DONE if remaining reaches 0 else READ; else hold (mem_we stays 0).
//   DONE: done=1 (err=1 if rejected) for exactly one cycle, busy=1; next cycle IDLE.
// - mem_we never asserted outside WRITE&mem_gnt; mem_addr holds last value in IDLE.
// - Latency with mem_gnt tied 1: accept at cycle 0, CHECK 1, READ/WRITE cycles 2..2N+1, done at 2N+2.
//   Each mem_gnt=0 cycle adds exactly one cycle.
// - Overlap: strictly ascending word-by-word copy; DST>SRC overlapping ranges propagate copied data (defined, not an error).
// - Range check uses 33-bit arithmetic: src+4*len-4 and dst+4*len-4 must not exceed limit; no pointer wrap can occur.
// CONFIGURATION
// - MEM_DMA_CHECKSUM_EN defined: checksum = 32-bit wrapping sum of all words read by the current command;
//   cleared to 0 on acceptance, updated on each granted READ, valid when done pulses, held until next acceptance; reset 0.
// - Not defined: checksum port and adder absent; all other behaviour identical.
// TESTING
// - Copy len=4, src=0x100, dst=0x200, RAM[0x40..0x43]=1,2,3,4, gnt=1 -> RAM[0x80..0x83]=1,2,3,4; done at cycle 10; err=0.
// - len=0 -> done at cycle 2, err=0, mem_we never 1, RAM unchanged.
// - src=0x102 (unaligned) or dst=0x3FFFC,len=2 (ADDR_LEN=16) -> done+err at cycle 2, no writes.
// - len=3, mem_gnt low on cycles 3 and 6 -> identical data, done delayed to cycle 10, no write while gnt=0.
// - rst pulsed after 2nd word written -> busy=0 next cycle, no done, only first 2 dst words updated; new command then works.
// - MEM_DMA_CHECKSUM_EN, copy 0xFFFFFFFF,0x00000002 -> checksum=0x00000001 at done; cmd_valid while busy ignored.

Source files
------------

// File: rtl/mem_dma_copier.sv
// rtl/mem_dma_copier.sv - word-by-word RAM copy engine with arbiter-gated bus access
// Optional running read checksum enabled by defining MEM_DMA_CHECKSUM_EN.
module mem_dma_copier #(
  parameter int ADDR_LEN = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_src,
  input  logic [31:0]      cmd_dst,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             mem_gnt,
  output logic [31:0]      mem_addr,
  output logic             mem_we,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
`ifdef MEM_DMA_CHECKSUM_EN
  ,
  output logic [31:0]      checksum
`endif
);

  localparam logic [32:0] BYTE_LIMIT = (33'd1 << (ADDR_LEN + 2)) - 33'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      src_ptr, dst_ptr, buffer, last_addr;
  logic [CNT_W-1:0] remaining;
  logic             rejected;

  logic [32:0]      span, src_last, dst_last;
  logic             check_fail;

  // Last-word addresses in 33 bits so a range that runs past 4 GiB cannot wrap into range.
  always_comb begin
    span       = {{(31 - CNT_W){1'b0}}, remaining, 2'b00};
    src_last   = {1'b0, src_ptr} + span - 33'd4;
    dst_last   = {1'b0, dst_ptr} + span - 33'd4;
    check_fail = (src_ptr[1:0] != 2'b00) || (dst_ptr[1:0] != 2'b00) ||
                 ((remaining != '0) && ((src_last > BYTE_LIMIT) || (dst_last > BYTE_LIMIT)));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (cmd_valid) state_nxt = S_CHECK;
      S_CHECK: state_nxt = (check_fail || remaining == '0) ? S_DONE : S_READ;
      S_READ:  if (mem_gnt) state_nxt = S_WRITE;
      S_WRITE: if (mem_gnt) state_nxt = (remaining == CNT_W'(1)) ? S_DONE : S_READ;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      buffer    <= '0;
      last_addr <= '0;
      remaining <= '0;
      rejected  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            src_ptr   <= cmd_src;
            dst_ptr   <= cmd_dst;
            remaining <= cmd_len;
            rejected  <= 1'b0;
          end
        end
        S_CHECK: rejected <= check_fail;
        S_READ: begin
          last_addr <= src_ptr;
          if (mem_gnt) begin
            buffer  <= mem_rdata;
            src_ptr <= src_ptr + 32'd4;
          end
        end
        S_WRITE: begin
          last_addr <= dst_ptr;
          if (mem_gnt) begin
            dst_ptr   <= dst_ptr + 32'd4;
            remaining <= remaining - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_DMA_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (state == S_IDLE && cmd_valid) begin
      checksum <= '0;
    end else if (state == S_READ && mem_gnt) begin
      checksum <= checksum + mem_rdata;
    end
  end
`endif

  // Address bus parks on the last driven address whenever no access is in flight.
  always_comb begin
    cmd_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    err       = (state == S_DONE) && rejected;
    mem_we    = (state == S_WRITE) && mem_gnt;
    mem_wdata = buffer;
    case (state)
      S_READ:  mem_addr = src_ptr;
      S_WRITE: mem_addr = dst_ptr;
      default: mem_addr = last_addr;
    endcase
  end

endmodule
